// File: rtl/mem_access_arbiter.sv
// Byte-serial memory sequencer shared by instruction fetch and the load/store unit.
// Round-robin arbitration, 1/2/4-beat little-endian transfers, RISC-V load extension.
module mem_access_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_type,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_done,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t              state_q, state_d;
    logic [1:0]          k_q, k_d, last_k_q, last_k_d;
    logic                gnt_lsu_q, gnt_lsu_d, last_lsu_q, last_lsu_d;
    logic                we_q, we_d, err_q, err_d;
    logic [2:0]          type_q, type_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, buf_q, buf_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, lsu_rdata_q, lsu_rdata_d;

    logic                pick_lsu, lsu_illegal;
    logic [1:0]          lsu_last_k;
    logic [DATA_W-1:0]   asm_w, ext_w, wshift;

    always_comb begin
        pick_lsu = lsu_req && (!if_req || !last_lsu_q);
        case (lsu_type)
            3'b000, 3'b100: begin lsu_illegal = 1'b0;         lsu_last_k = 2'd0; end
            3'b001, 3'b101: begin lsu_illegal = lsu_addr[0];  lsu_last_k = 2'd1; end
            3'b010:         begin lsu_illegal = |lsu_addr[1:0]; lsu_last_k = 2'd3; end
            default:        begin lsu_illegal = 1'b1;         lsu_last_k = 2'd3; end
        endcase
    end

    // Assembled word including the byte arriving in the current beat.
    always_comb begin
        asm_w = buf_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (k_q == 2'(i)) asm_w[8*i +: 8] = mem_rdata;
        end
        case (type_q)
            3'b000:  ext_w = {{(DATA_W-8){asm_w[7]}}, asm_w[7:0]};
            3'b001:  ext_w = {{(DATA_W-16){asm_w[15]}}, asm_w[15:0]};
            3'b100:  ext_w = {{(DATA_W-8){1'b0}}, asm_w[7:0]};
            3'b101:  ext_w = {{(DATA_W-16){1'b0}}, asm_w[15:0]};
            default: ext_w = asm_w;
        endcase
        wshift = wdata_q >> {k_q, 3'b000};
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        last_k_d    = last_k_q;
        gnt_lsu_d   = gnt_lsu_q;
        last_lsu_d  = last_lsu_q;
        we_d        = we_q;
        err_d       = err_q;
        type_d      = type_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        if_rdata_d  = if_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        if_done     = 1'b0;
        if_err      = 1'b0;
        lsu_done    = 1'b0;
        lsu_err     = 1'b0;
        mem_addr    = '0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = '0;

        case (state_q)
            IDLE: begin
                if (if_req || lsu_req) begin
                    gnt_lsu_d  = pick_lsu;
                    last_lsu_d = pick_lsu;
                    k_d        = '0;
                    buf_d      = '0;
                    if (pick_lsu) begin
                        addr_d   = lsu_addr;
                        type_d   = lsu_type;
                        we_d     = lsu_we;
                        wdata_d  = lsu_wdata;
                        err_d    = lsu_illegal;
                        last_k_d = lsu_last_k;
                    end else begin
                        addr_d   = if_addr;
                        type_d   = 3'b010;
                        we_d     = 1'b0;
                        wdata_d  = '0;
                        err_d    = |if_addr[1:0];
                        last_k_d = 2'd3;
                    end
                    if (err_d) begin
                        state_d = RESP;
                        if (pick_lsu) lsu_rdata_d = '0;
                        else          if_rdata_d  = '0;
                    end else begin
                        state_d = XFER;
                    end
                end
            end
            XFER: begin
                mem_addr = addr_q + ADDR_W'(k_q);
                if (we_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = wshift[7:0];
                end else begin
                    mem_re = 1'b1;
                    buf_d  = asm_w;
                end
                k_d = k_q + 2'd1;
                if (k_q == last_k_q) begin
                    state_d = RESP;
                    k_d     = '0;
                    if (gnt_lsu_q) lsu_rdata_d = we_q ? '0 : ext_w;
                    else           if_rdata_d  = asm_w;
                end
            end
            RESP: begin
                if_done  = !gnt_lsu_q;
                if_err   = !gnt_lsu_q && err_q;
                lsu_done = gnt_lsu_q;
                lsu_err  = gnt_lsu_q && err_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            last_k_q    <= '0;
            gnt_lsu_q   <= 1'b0;
            last_lsu_q  <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            type_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            if_rdata_q  <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            last_k_q    <= last_k_d;
            gnt_lsu_q   <= gnt_lsu_d;
            last_lsu_q  <= last_lsu_d;
            we_q        <= we_d;
            err_q       <= err_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            if_rdata_q  <= if_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign lsu_rdata = lsu_rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed scenarios plus randomized
// transactions checked against a byte-array memory and arithmetic load model.
module tb_mem_access_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_done, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        lsu_req, lsu_we, lsu_done, lsu_err;
    logic [2:0]  lsu_type;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [31:0] mem_addr;
    logic        mem_re, mem_we;
    logic [7:0]  mem_wdata, mem_rdata;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0]  mem [0:4095];
    logic [31:0] bq_a[$];
    logic [7:0]  bq_d[$];
    logic        bq_w[$];

    always #5 clk = ~clk;

    mem_access_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_type(lsu_type), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[11:0]];
    always @(posedge clk) if (mem_we) mem[mem_addr[11:0]] <= mem_wdata;

    // Strobe hygiene and beat capture, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            ntests++;
            if (mem_re && mem_we) begin
                nfail++;
                $display("FAIL strobe_excl: re=%0b we=%0b, required not both 1", mem_re, mem_we);
            end
            if (!mem_re && !mem_we && (mem_addr !== 32'h0 || mem_wdata !== 8'h0)) begin
                nfail++;
                $display("FAIL idle_bus: addr=%h wdata=%h, required 0/0", mem_addr, mem_wdata);
            end
            if (mem_re || mem_we) begin
                bq_a.push_back(mem_addr);
                bq_d.push_back(mem_we ? mem_wdata : mem_rdata);
                bq_w.push_back(mem_we);
            end
        end
    end

    function automatic int nbytes(input logic [2:0] ty);
        case (ty[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit illegal(input logic [2:0] ty, input logic [31:0] a);
        if (ty == 3'd3 || ty == 3'd6 || ty == 3'd7) return 1'b1;
        return (a % nbytes(ty)) != 0;
    endfunction

    function automatic logic [31:0] mem_bytes(input logic [31:0] a, input int n);
        logic [31:0] d = '0;
        for (int i = 0; i < n; i++) d[8*i +: 8] = mem[12'(a + 32'(i))];
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] ty, input logic [31:0] a);
        int     n = nbytes(ty);
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(mem[12'(a + 32'(i))]) << (8*i);
        if (!ty[2] && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    function automatic bit beats_ok(input logic we, input logic [31:0] a, input int n,
                                    input logic [31:0] d);
        if (bq_a.size() != n) return 1'b0;
        for (int i = 0; i < n; i++) begin
            if (bq_a[i] !== a + 32'(i) || bq_d[i] !== d[8*i +: 8] || bq_w[i] !== we) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic lsu_txn(input logic we, input logic [2:0] ty, input logic [31:0] a,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output logic er);
        bq_a.delete(); bq_d.delete(); bq_w.delete();
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_we = we; lsu_type = ty; lsu_addr = a; lsu_wdata = wd;
        lat = 0;
        forever begin
            @(negedge clk);
            if (lsu_done || lat > 40) break;
            lat++;
        end
        rd = lsu_rdata; er = lsu_err;
        lsu_req = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] a, input bit drop, output int lat,
                          output logic [31:0] rd, output logic er);
        bq_a.delete(); bq_d.delete(); bq_w.delete();
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = a;
        lat = 0;
        forever begin
            @(negedge clk);
            if (if_done || lat > 40) break;
            if (drop && lat == 2) if_req = 1'b0;
            lat++;
        end
        rd = if_rdata; er = if_err;
        if_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ntests++;
        if ({if_done, if_err, lsu_done, lsu_err, mem_re, mem_we} !== 6'b0 ||
            if_rdata !== 32'h0 || lsu_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 8'h0) begin
            nfail++;
            $display("FAIL reset_outputs: ifr=%h lsr=%h ma=%h strobes=%b, required all 0",
                     if_rdata, lsu_rdata, mem_addr, {if_done, if_err, lsu_done, lsu_err, mem_re, mem_we});
        end
        rst_n = 1'b1;
        @(negedge clk);
        ntests++;
        if ({if_done, lsu_done, mem_re, mem_we} !== 4'b0) begin
            nfail++;
            $display("FAIL reset_idle: done/strobes=%b, required 0000", {if_done, lsu_done, mem_re, mem_we});
        end
    endtask

    task automatic test_store_word();
        int lat; logic [31:0] rd; logic er;
        lsu_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, lat, rd, er);
        ntests++;
        if (lat !== 5 || er !== 1'b0 || rd !== 32'h0) begin
            nfail++;
            $display("FAIL sw_resp: lat=%0d err=%0b rdata=%h, required 5/0/0", lat, er, rd);
        end
        ntests++;
        if (!beats_ok(1'b1, 32'h100, 4, 32'hDEADBEEF)) begin
            nfail++;
            $display("FAIL sw_beats: n=%0d first=%h, required 4 writes 100..103 EF BE AD DE",
                     bq_a.size(), bq_a.size() > 0 ? bq_a[0] : 32'hX);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  tys [4]  = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] adrs [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD};
        int          lats [4] = '{2, 2, 3, 3};
        int lat; logic [31:0] rd; logic er;
        for (int i = 0; i < 4; i++) begin
            lsu_txn(1'b0, tys[i], adrs[i], 32'h0, lat, rd, er);
            ntests++;
            if (rd !== exps[i] || lat !== lats[i] || er !== 1'b0) begin
                nfail++;
                $display("FAIL load_%0d: rdata=%h lat=%0d err=%0b, required %h/%0d/0",
                         i, rd, lat, er, exps[i], lats[i]);
            end
            ntests++;
            if (!beats_ok(1'b0, adrs[i], lats[i] - 1, mem_bytes(adrs[i], lats[i] - 1))) begin
                nfail++;
                $display("FAIL load_beats_%0d: n=%0d, required %0d reads", i, bq_a.size(), lats[i] - 1);
            end
        end
    endtask

    task automatic test_illegal();
        int lat; logic [31:0] rd; logic er;
        lsu_txn(1'b0, 3'b010, 32'h101, 32'h0, lat, rd, er);
        ntests++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || bq_a.size() != 0) begin
            nfail++;
            $display("FAIL lw_misalign: err=%0b rdata=%h lat=%0d beats=%0d, required 1/0/1/0",
                     er, rd, lat, bq_a.size());
        end
        lsu_txn(1'b1, 3'b011, 32'h100, 32'h12345678, lat, rd, er);
        ntests++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || bq_a.size() != 0) begin
            nfail++;
            $display("FAIL type_011: err=%0b rdata=%h lat=%0d beats=%0d, required 1/0/1/0",
                     er, rd, lat, bq_a.size());
        end
        if_txn(32'h6, 1'b0, lat, rd, er);
        ntests++;
        if (er !== 1'b1 || rd !== 32'h0 || lat !== 1 || bq_a.size() != 0) begin
            nfail++;
            $display("FAIL if_misalign: err=%0b rdata=%h lat=%0d beats=%0d, required 1/0/1/0",
                     er, rd, lat, bq_a.size());
        end
    endtask

    task automatic test_if_fetch();
        int lat; logic [31:0] rd; logic er;
        if_txn(32'h100, 1'b1, lat, rd, er);
        ntests++;
        if (rd !== 32'hDEADBEEF || lat !== 5 || er !== 1'b0) begin
            nfail++;
            $display("FAIL if_fetch_drop: rdata=%h lat=%0d err=%0b, required DEADBEEF/5/0", rd, lat, er);
        end
        ntests++;
        if (!beats_ok(1'b0, 32'h100, 4, 32'hDEADBEEF)) begin
            nfail++;
            $display("FAIL if_beats: n=%0d, required 4 reads at 100..103", bq_a.size());
        end
    endtask

    task automatic test_arbitration();
        int          cyc = 0;
        int          got_w[$];
        int          got_t[$];
        int          both = 0;
        int          bad_data = 0;
        int          last = 0;
        int          t = 0;
        int          ew[3];
        int          et[3];
        logic [31:0] exp_if, exp_ls;
        do_reset();
        exp_if = exp_load(3'b010, 32'h100);
        exp_ls = exp_load(3'b010, 32'h104);
        for (int g = 0; g < 3; g++) begin
            ew[g] = (last == 0) ? 1 : 0;
            last  = ew[g];
            et[g] = t + 5;
            t     = t + 6;
        end
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 32'h100;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = 3'b010; lsu_addr = 32'h104; lsu_wdata = '0;
        while (got_w.size() < 3 && cyc < 60) begin
            @(negedge clk);
            if (if_done && lsu_done) both++;
            if (lsu_done) begin
                got_w.push_back(1); got_t.push_back(cyc);
                if (lsu_rdata !== exp_ls) bad_data++;
            end else if (if_done) begin
                got_w.push_back(0); got_t.push_back(cyc);
                if (if_rdata !== exp_if) bad_data++;
            end
            cyc++;
        end
        if_req = 1'b0; lsu_req = 1'b0;
        ntests++;
        if (got_w.size() != 3) begin
            nfail++;
            $display("FAIL arb_count: %0d grants in %0d cycles, required 3", got_w.size(), cyc);
        end else begin
            for (int g = 0; g < 3; g++) begin
                ntests++;
                if (got_w[g] != ew[g] || got_t[g] != et[g]) begin
                    nfail++;
                    $display("FAIL arb_grant_%0d: lsu=%0d at %0d, required lsu=%0d at %0d",
                             g, got_w[g], got_t[g], ew[g], et[g]);
                end
            end
        end
        ntests++;
        if (both != 0 || bad_data != 0) begin
            nfail++;
            $display("FAIL arb_data: both_done=%0d bad_rdata=%0d, required 0/0", both, bad_data);
        end
    endtask

    task automatic test_reset_mid_xfer();
        int lat; logic [31:0] rd; logic er;
        int spurious = 0;
        logic [31:0] got;
        for (int i = 0; i < 4; i++) mem[12'h200 + 12'(i)] <= 8'hAA;
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_type = 3'b010; lsu_addr = 32'h200; lsu_wdata = 32'h11223344;
        repeat (4) @(negedge clk);
        ntests++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h202) begin
            nfail++;
            $display("FAIL rst_pre: we=%0b addr=%h, required 1/202", mem_we, mem_addr);
        end
        rst_n = 1'b0;
        lsu_req = 1'b0;
        #1;
        ntests++;
        if (mem_we !== 1'b0 || lsu_done !== 1'b0) begin
            nfail++;
            $display("FAIL rst_abort: we=%0b done=%0b, required 0/0", mem_we, lsu_done);
        end
        repeat (3) begin
            @(negedge clk);
            if (lsu_done !== 1'b0 || mem_we !== 1'b0) spurious++;
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (lsu_done !== 1'b0 || if_done !== 1'b0) spurious++;
        end
        got = mem_bytes(32'h200, 4);
        ntests++;
        if (spurious != 0 || got !== 32'hAAAA3344) begin
            nfail++;
            $display("FAIL rst_partial: spurious=%0d mem=%h, required 0/AAAA3344", spurious, got);
        end
        lsu_txn(1'b0, 3'b010, 32'h200, 32'h0, lat, rd, er);
        ntests++;
        if (rd !== 32'hAAAA3344 || lat !== 5 || er !== 1'b0) begin
            nfail++;
            $display("FAIL rst_recover: rdata=%h lat=%0d err=%0b, required AAAA3344/5/0", rd, lat, er);
        end
    endtask

    task automatic test_random();
        logic [2:0]  tys [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd2};
        int lat, n, elat;
        logic [31:0] rd, a, wd, erd, ed;
        logic er, we, il;
        logic [2:0] ty;
        for (int it = 0; it < 60; it++) begin
            a = 32'h300 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 2) != 0) a = a & ~32'h3;
                il   = (a % 4) != 0;
                elat = il ? 1 : 5;
                erd  = il ? 32'h0 : exp_load(3'b010, a);
                ed   = mem_bytes(a, 4);
                if_txn(a, 1'b0, lat, rd, er);
                we = 1'b0; n = il ? 0 : 4;
            end else begin
                ty  = tys[$urandom_range(0, 7)];
                we  = 1'($urandom_range(0, 1));
                wd  = $urandom;
                il  = illegal(ty, a);
                n   = il ? 0 : nbytes(ty);
                elat = il ? 1 : n + 1;
                erd = (il || we) ? 32'h0 : exp_load(ty, a);
                ed  = we ? wd : mem_bytes(a, n);
                lsu_txn(we, ty, a, wd, lat, rd, er);
            end
            ntests++;
            if (rd !== erd || er !== il || lat !== elat || !beats_ok(we, a, n, ed)) begin
                nfail++;
                $display("FAIL rand_%0d: a=%h we=%0b rdata=%h err=%0b lat=%0d beats=%0d, required %h/%0b/%0d/%0d",
                         it, a, we, rd, er, lat, bq_a.size(), erd, il, elat, n);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_type = '0; lsu_addr = '0; lsu_wdata = '0;
        for (int i = 0; i < 4096; i++) mem[i] <= 8'($urandom);
        #1;
        test_reset();
        test_store_word();
        test_loads();
        test_illegal();
        test_if_fetch();
        test_arbitration();
        test_reset_mid_xfer();
        test_random();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sequences and shares the byte-wide external data memory between the instruction-fetch (IF) port and the load/store unit (LSU) port of the RV32IM core. Each granted request is split into 1, 2 or 4 single-byte memory beats, assembled little-endian, and sign- or zero-extended per RISC-V funct3. Misaligned or illegal requests are rejected without touching memory. Sits between the core's IF/LSU stages and the byte-addressed memory array.

## Interface
- ADDR_W, 32, address width of requester and memory ports
- DATA_W, 32, requester data width (fixed at 32; 4 bytes max per access)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  IF request; held with if_addr until if_done
- if_addr  in  ADDR_W  fetch byte address (always word access)
- if_done  out  1  one-cycle pulse: IF transaction complete
- if_rdata  out  32  fetched word, valid with if_done, held until next IF grant
- if_err  out  1  with if_done: misaligned fetch
- lsu_req  in  1  LSU request; held with other lsu_* inputs until lsu_done
- lsu_we  in  1  1 = store, 0 = load
- lsu_type  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- lsu_addr  in  ADDR_W  byte address
- lsu_wdata  in  32  store data (low bytes used)
- lsu_done  out  1  one-cycle pulse: LSU transaction complete
- lsu_rdata  out  32  extended load data, valid with lsu_done, held until next LSU grant
- lsu_err  out  1  with lsu_done: misaligned or illegal type
- mem_addr  out  ADDR_W  byte address to memory
- mem_re  out  1  read beat strobe
- mem_we  out  1  write beat strobe
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte, combinational from mem_addr, sampled at beat end

## Operation
- States: IDLE, XFER, RESP.
- IDLE: if any req, arbitrate, latch addr/type/we/wdata of winner, set beat counter k=0, beat count N (B/BU 1, H/HU 2, W and IF 4). Legal → XFER; illegal → RESP with err.
- Arbitration: round-robin on last_grant. Only one requesting → it wins. Both → the one not last granted. last_grant resets to IF (first tie goes to LSU).
- Illegal: lsu_type in {011,110,111}; H/HU with addr[0]=1; W or IF with addr[1:0]≠0. No memory beat; rdata cleared to 0.
- XFER: mem_addr = base + k (mod 2^ADDR_W); load: mem_re=1, byte k captured into rdata[8k+7:8k]; store: mem_we=1, mem_wdata = wdata[8k+7:8k]. k increments; after beat N-1 → RESP.
- RESP: done=1 for granted port for one cycle; rdata output = assembled value, sign-extended (B, H) or zero-extended (BU, HU); stores return rdata 0; err as determined. → IDLE.
- Requester dropping req mid-transaction is ignored; transaction completes and done still pulses.
- mem_re/mem_we never both high; both 0 outside XFER; mem_addr and mem_wdata 0 outside XFER.

## Timing
- Reset (async assert, sync-to-clock deassert by integrator): state IDLE, k=0, last_grant=IF, all outputs 0 (done, err, rdata, mem_*). Reset mid-XFER aborts immediately: mem_we drops, already-written bytes remain, no done issued.
- Request seen in IDLE at cycle T: beats at T+1..T+N, done at T+N+1, state IDLE at T+N+2. Word: done at T+5; byte: T+2; illegal: done at T+1.
- Minimum one IDLE cycle between transactions; a req held high through done is re-arbitrated at T+N+2 as a new transaction.
- Requests arriving during XFER/RESP wait; no loss.

## Test plan
- Reset, then LSU SW addr 0x100 wdata 0xDEADBEEF → mem_we beats at 0x100..0x103 bytes EF,BE,AD,DE; lsu_done at T+5, lsu_err 0.
- LSU LB then LBU addr 0x103 (byte 0xDE) → lsu_rdata 0xFFFFFFDE then 0x000000DE, each done at T+2; LH addr 0x102 → 0xFFFFDEAD.
- if_req and lsu_req both asserted from IDLE after reset → LSU granted first, IF granted next IDLE; with both held continuously, grants alternate LSU, IF, LSU.
- LSU LW addr 0x101 and lsu_type 011 → lsu_err 1, lsu_rdata 0, done at T+1, mem_re/mem_we never asserted; IF addr 0x6 → if_err 1.
- rst_n low during beat 2 of SW → mem_we 0 immediately, no lsu_done, bytes 0,1 written; after reset next request served normally.
- IF fetch addr 0x100 after SW above → if_rdata 0xDEADBEEF at T+5; if_req dropped at T+2 → if_done still pulses at T+5.
